spi_apb_arbiter: RTL and testbench
==================================

SPI_APB_ARBITER -- requirements
Module: spi_apb_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, max ACCESS-phase cycles waiting for PREADY before abort (legal range 1..255).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 (CPU bridge) transfer request; held until req0_ready.
REQ-005 req0_write  input  1  requester 0 direction (1 = write).
REQ-006 req0_addr  input  3  requester 0 SPI register index.
REQ-007 req0_wdata  input  8  requester 0 write data.
REQ-008 req0_ready  output  1  one-cycle completion pulse to requester 0.
REQ-009 req0_rdata  output  8  requester 0 read data, valid while req0_ready high.
REQ-010 req0_err  output  1  requester 0 error flag (PSLVERR or timeout), valid while req0_ready high.
REQ-011 req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_rdata, req1_err: identical to REQ-004..010 for requester 1 (DMA).
REQ-012 PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
REQ-013 PADDR  output  3  APB address; PWDATA  output  8  APB write data.
REQ-014 PRDATA  input  8; PREADY  input  1; PSLVERR  input  1  APB slave response.
REQ-015 busy  output  1  high in any state except IDLE; grant  output  1  index of current owner, meaningful while busy.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS, DONE; all outputs registered.
REQ-017 IDLE: if any reqN_valid, select owner, latch its write/addr/wdata into PWRITE/PADDR/PWDATA, set PSEL=1, PENABLE=0, go SETUP; else stay.
REQ-018 Arbitration round-robin: single requester wins outright; both valid -> grant the one not served last; last-served pointer updates on entry to DONE.
REQ-019 SETUP: exactly one cycle; set PENABLE=1, go ACCESS.
REQ-020 ACCESS with PREADY=1: PSEL=0, PENABLE=0, owner ready=1, err=PSLVERR, rdata=PRDATA on reads / 8'h00 on writes, go DONE.
REQ-021 ACCESS with PREADY=0: increment wait counter; when counter reaches TIMEOUT, terminate as REQ-020 with err=1, rdata=8'h00.
REQ-022 Wait counter clears on entry to SETUP; width 8 bits.
REQ-023 DONE: exactly one cycle; owner ready high only here; then ready=0, go IDLE; no request sampled in DONE.
REQ-024 PADDR, PWRITE, PWDATA stable from SETUP through final ACCESS cycle; change only in IDLE on grant.
REQ-025 Non-owner ready/err always 0; reqN_rdata holds last value outside its ready pulse.
REQ-026 Owner dropping valid mid-transfer does not abort; transfer completes and ready still pulses.
REQ-027 Latency: valid seen in IDLE at edge N -> SETUP cycle N+1 -> ACCESS N+2 -> (PREADY=1) ready high cycle N+3; minimum 4 cycles per transfer.
REQ-028 Requester must deassert valid on the edge it samples ready; a still-high valid in following IDLE is a new request.

Reset
REQ-029 rst=1 at an edge: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req0/1_ready=0, req0/1_err=0, req0/1_rdata=0, busy=0, grant=0, counter=0, last-served=1 (requester 0 wins first tie).
REQ-030 Reset mid-transfer (any state) aborts silently: no ready pulse, bus idle next cycle.

Verification
REQ-031 Single read: req0 valid, addr=3, PREADY=1 first ACCESS, PRDATA=8'hA5 -> PSEL 2 cycles, PENABLE 1 cycle, req0_ready one pulse with rdata=8'hA5, err=0.
REQ-032 Simultaneous: both valid from reset, 3 transfers each -> grant order 0,1,0,1,0,1; each ready pulses once per transfer.
REQ-033 Wait states: req1 write wdata=8'h3C, PREADY low 5 cycles -> PWDATA/PADDR stable 7 cycles, req1_ready 1 pulse, rdata=8'h00, err=0.
REQ-034 Timeout: TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS wait cycles then termination, req0_err=1, rdata=8'h00, FSM back to IDLE.
REQ-035 Slave error: PSLVERR=1 with PREADY=1 on read PRDATA=8'h11 -> err=1, rdata=8'h11.
REQ-036 rst asserted in ACCESS -> next cycle PSEL=PENABLE=0, no ready pulse; subsequent tie grants requester 0.

Source files
------------

// File: rtl/spi_apb_arbiter.sv
// spi_apb_arbiter
//   Two-requester round-robin arbiter driving a single APB master port that
//   talks to an SPI controller register file. One transfer is in flight at a
//   time: IDLE -> SETUP -> ACCESS (wait states / timeout) -> DONE -> IDLE.
//   All outputs are registered.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata  requester N command (held until reqN_ready)
//   reqN_ready/rdata/err     one-cycle completion pulse, read data, error flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB master controls
//   PRDATA/PREADY/PSLVERR    APB slave response
//   busy                     high whenever the FSM is not in IDLE
//   grant                    index of the current owner (meaningful while busy)
//
// Parameter
//   TIMEOUT  ACCESS cycles (with PREADY low) after which the transfer is
//            terminated with an error. Legal range 1..255.
module spi_apb_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [2:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic [7:0] req0_rdata,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [2:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic [7:0] req1_rdata,
  output logic       req1_err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [2:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  output logic       busy,
  output logic       grant
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  // The wait counter equals the index of the current ACCESS cycle, so the
  // transfer is cut off on the TIMEOUT-th ACCESS cycle that still sees no PREADY.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] wait_q;
  logic       last_q;     // requester served most recently

  logic       pick_d;
  logic       finish_d;
  logic       err_d;
  logic [7:0] rdata_d;

  always_comb begin
    // Tie goes to whoever was not served last; otherwise the lone requester.
    pick_d   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    finish_d = PREADY || (wait_q == WAIT_LAST);
    err_d    = PREADY ? PSLVERR : 1'b1;
    rdata_d  = (PREADY && !PWRITE) ? PRDATA : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= 8'd0;
      last_q     <= 1'b1;   // requester 0 wins the first tie
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= 3'd0;
      PWDATA     <= 8'h00;
      req0_ready <= 1'b0;
      req0_err   <= 1'b0;
      req0_rdata <= 8'h00;
      req1_ready <= 1'b0;
      req1_err   <= 1'b0;
      req1_rdata <= 8'h00;
      busy       <= 1'b0;
      grant      <= 1'b0;
    end else begin
      // ready/err only ever live for the single DONE cycle
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant   <= pick_d;
            PWRITE  <= pick_d ? req1_write : req0_write;
            PADDR   <= pick_d ? req1_addr  : req0_addr;
            PWDATA  <= pick_d ? req1_wdata : req0_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            busy    <= 1'b1;
            wait_q  <= 8'd0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (finish_d) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            last_q  <= grant;
            state_q <= DONE;
            if (grant) begin
              req1_ready <= 1'b1;
              req1_err   <= err_d;
              req1_rdata <= rdata_d;
            end else begin
              req0_ready <= 1'b1;
              req0_err   <= err_d;
              req0_rdata <= rdata_d;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE: begin
          // requests are deliberately not sampled here
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_apb_arbiter.sv
module tb_spi_apb_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req0_write, req0_ready, req0_err;
  logic [2:0] req0_addr;
  logic [7:0] req0_wdata, req0_rdata;
  logic       req1_valid, req1_write, req1_ready, req1_err;
  logic [2:0] req1_addr;
  logic [7:0] req1_wdata, req1_rdata;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy, grant;
  logic [2:0] PADDR;
  logic [7:0] PWDATA, PRDATA;

  spi_apb_arbiter #(.TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .grant(grant)
  );

  // Second instance with a short timeout and a slave that never answers.
  logic       t_rst, t_v, t_ready, t_err, t_psel, t_pen, t_pwr, t_busy, t_grant;
  logic [7:0] t_rdata, t_pwdata, t_r1rdata;
  logic [2:0] t_paddr;
  logic       t_r1ready, t_r1err;

  spi_apb_arbiter #(.TIMEOUT(4)) u_dut_to (
    .clk(clk), .rst(t_rst),
    .req0_valid(t_v), .req0_write(1'b0), .req0_addr(3'd5), .req0_wdata(8'h00),
    .req0_ready(t_ready), .req0_rdata(t_rdata), .req0_err(t_err),
    .req1_valid(1'b0), .req1_write(1'b0), .req1_addr(3'd0), .req1_wdata(8'h00),
    .req1_ready(t_r1ready), .req1_rdata(t_r1rdata), .req1_err(t_r1err),
    .PSEL(t_psel), .PENABLE(t_pen), .PWRITE(t_pwr), .PADDR(t_paddr),
    .PWDATA(t_pwdata), .PRDATA(8'h5A), .PREADY(1'b0), .PSLVERR(1'b0),
    .busy(t_busy), .grant(t_grant)
  );

  int tests = 0, fails = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct { bit own; logic [7:0] rd; bit err; } exp_t;
  exp_t sbq[$];
  bit   glog[$];

  // requester model state
  bit         v[2], bz[2], r_wr[2], fx_en[2], fx_wr[2];
  logic [2:0] r_ad[2], fx_ad[2];
  logic [7:0] r_wd[2], fx_wd[2];
  int         quota[2];
  int         prob;
  bit         drop_en;
  // slave model state
  int         fx_w, w, k;
  bit         fx_rsp, fx_er, s_er;
  logic [7:0] fx_prd, s_prd;
  // arbitration / bookkeeping
  bit         lastsrv, own, do_reset;
  int         rst_hold, nsel, nen;
  logic [2:0] c_ad;
  logic       c_wr;
  logic [7:0] c_wd;

  assign req0_valid = v[0];
  assign req0_write = r_wr[0];
  assign req0_addr  = r_ad[0];
  assign req0_wdata = r_wd[0];
  assign req1_valid = v[1];
  assign req1_write = r_wr[1];
  assign req1_addr  = r_ad[1];
  assign req1_wdata = r_wd[1];

  // Stimulus + slave + expectation generation: all inputs change on negedge.
  always @(negedge clk) begin
    if (do_reset) begin
      rst = 1'b1; rst_hold = 1; do_reset = 1'b0;
      sbq.delete(); v = '{0, 0}; bz = '{0, 0}; lastsrv = 1'b1; PREADY = 1'b0;
    end else if (rst) begin
      chk("rst_psel", PSEL, 0);       chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);   chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);   chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      chk("rst_err", {req1_err, req0_err}, 0);
      chk("rst_rdata", {req1_rdata, req0_rdata}, 0);
      if (rst_hold == 0) rst = 1'b0; else rst_hold--;
    end else begin
      if (PSEL) nsel++;
      if (PENABLE) nen++;
      if (PSEL && !PENABLE) begin
        // first bus cycle of a transfer: decide who should own it
        chk("setup_has_req", v[0] | v[1], 1);
        own = (v[0] && v[1]) ? !lastsrv : v[1];
        chk("grant", grant, own);
        chk("busy", busy, 1);
        chk("setup_paddr", PADDR, r_ad[own]);
        chk("setup_pwrite", PWRITE, r_wr[own]);
        chk("setup_pwdata", PWDATA, r_wd[own]);
        c_ad = PADDR; c_wr = PWRITE; c_wd = PWDATA;
        bz[own] = 1'b1; lastsrv = own; glog.push_back(own);
        if (fx_w >= 0) w = fx_w;
        else if ($urandom_range(0, 5) == 0) w = $urandom_range(0, TO + 3);
        else w = $urandom_range(0, 3);
        s_prd = fx_rsp ? fx_prd : 8'($urandom);
        s_er  = fx_rsp ? fx_er  : ($urandom_range(0, 3) == 0);
        sbq.push_back('{own: own,
                        rd:  (w >= TO || r_wr[own]) ? 8'h00 : s_prd,
                        err: (w >= TO) ? 1'b1 : s_er});
        k = 0;
        PREADY = 1'($urandom); PRDATA = 8'($urandom); PSLVERR = 1'($urandom);
      end else if (PSEL && PENABLE) begin
        chk("access_paddr_stable", PADDR, c_ad);
        chk("access_pwrite_stable", PWRITE, c_wr);
        chk("access_pwdata_stable", PWDATA, c_wd);
        PREADY  = (k == w);
        PRDATA  = (k == w) ? s_prd : 8'($urandom);
        PSLVERR = (k == w) ? s_er  : 1'($urandom);
        k++;
        for (int n = 0; n < 2; n++)
          if (drop_en && bz[n] && v[n] && $urandom_range(0, 5) == 0) v[n] = 1'b0;
      end else begin
        PREADY = 1'($urandom); PRDATA = 8'($urandom); PSLVERR = 1'($urandom);
      end
      if (req0_ready) begin v[0] = 1'b0; bz[0] = 1'b0; end
      if (req1_ready) begin v[1] = 1'b0; bz[1] = 1'b0; end
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && !bz[n] && quota[n] > 0 && $urandom_range(1, 100) <= prob) begin
          v[n] = 1'b1; quota[n]--;
          r_wr[n] = fx_en[n] ? fx_wr[n] : 1'($urandom);
          r_ad[n] = fx_en[n] ? fx_ad[n] : 3'($urandom);
          r_wd[n] = fx_en[n] ? fx_wd[n] : 8'($urandom);
        end
      end
    end
  end

  // Monitor: compares every completion pulse against the scoreboard.
  logic [7:0] lrd[2];
  initial begin
    exp_t e;
    bit   who;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        lrd[0] = 8'h00; lrd[1] = 8'h00;
      end else begin
        if (req0_ready || req1_ready) begin
          chk("ready_exclusive", req0_ready & req1_ready, 0);
          who = req1_ready;
          chk("sb_nonempty", sbq.size() > 0, 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("owner", who, e.own);
            chk("rdata", who ? req1_rdata : req0_rdata, e.rd);
            chk("err", who ? req1_err : req0_err, e.err);
            chk("nonowner_err", who ? req0_err : req1_err, 0);
          end
          if (who) lrd[1] = req1_rdata; else lrd[0] = req0_rdata;
        end
        if (!req0_ready) begin
          chk("idle_err0", req0_err, 0); chk("hold_rdata0", req0_rdata, lrd[0]);
        end
        if (!req1_ready) begin
          chk("idle_err1", req1_err, 0); chk("hold_rdata1", req1_rdata, lrd[1]);
        end
      end
    end
  end

  task automatic wait_idle(int budget);
    int c = 0;
    do begin @(posedge clk); #1; c++; end
    while (c < budget && !(quota[0] == 0 && quota[1] == 0 && !v[0] && !v[1] &&
                           !bz[0] && !bz[1] && sbq.size() == 0 && !busy));
    chk("drain_in_budget", c < budget, 1);
  endtask

  task automatic reset_dut();
    int c = 0;
    do_reset = 1'b1;
    do begin @(posedge clk); #1; c++; end while (c < 20 && (do_reset || rst));
    chk("reset_done", c < 20, 1);
  endtask

  task automatic directed(bit n, bit wr, logic [2:0] ad, logic [7:0] wd,
                          int wt, logic [7:0] prd, bit er);
    fx_en = '{0, 0}; fx_en[n] = 1'b1; fx_wr[n] = wr; fx_ad[n] = ad; fx_wd[n] = wd;
    fx_w = wt; fx_rsp = 1'b1; fx_prd = prd; fx_er = er;
    nsel = 0; nen = 0; quota[n] = 1;
  endtask

  initial begin
    int acc, c;
    bit seen;
    logic e1;
    logic [7:0] r1;
    rst = 1'b1; rst_hold = 2; do_reset = 1'b0; lastsrv = 1'b1;
    v = '{0, 0}; bz = '{0, 0}; quota = '{0, 0}; prob = 100; drop_en = 1'b0;
    fx_en = '{0, 0}; fx_w = -1; fx_rsp = 1'b0;
    r_wr = '{0, 0}; r_ad = '{3'd0, 3'd0}; r_wd = '{8'h00, 8'h00};
    PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0;
    t_rst = 1'b1; t_v = 1'b0;
    repeat (5) @(posedge clk); #1;

    // single read, zero wait states
    directed(0, 0, 3'd3, 8'h00, 0, 8'hA5, 0);
    wait_idle(50);
    chk("single_psel_cycles", nsel, 2);
    chk("single_penable_cycles", nen, 1);

    // simultaneous requests straight out of reset alternate
    reset_dut();
    fx_en = '{0, 0}; fx_w = -1; fx_rsp = 1'b0; glog.delete();
    quota = '{3, 3};
    wait_idle(600);
    chk("rr_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);

    // write with five wait states
    directed(1, 1, 3'd6, 8'h3C, 5, 8'hEE, 0);
    wait_idle(50);
    chk("wait_psel_cycles", nsel, 7);
    chk("wait_penable_cycles", nen, 6);

    // slave error on a read still returns the data
    directed(0, 0, 3'd1, 8'h00, 1, 8'h11, 1);
    wait_idle(50);

    // reset during ACCESS aborts silently, then requester 0 wins the tie
    directed(0, 0, 3'd2, 8'h00, 10, 8'h77, 0);
    c = 0;
    do begin @(posedge clk); #1; c++; end while (c < 20 && !(PSEL && PENABLE));
    chk("reached_access", PSEL && PENABLE, 1);
    reset_dut();
    fx_en = '{0, 0}; fx_w = -1; fx_rsp = 1'b0; glog.delete();
    quota = '{1, 1};
    wait_idle(100);
    chk("post_reset_grants", glog.size(), 2);
    if (glog.size() > 0) chk("post_reset_tie", glog[0], 0);

    // randomized traffic, dense then sparse
    drop_en = 1'b1;
    prob = 100; quota = '{40, 40};
    wait_idle(4000);
    prob = 25; quota = '{40, 40};
    wait_idle(4000);
    drop_en = 1'b0;

    // timeout on the short-timeout instance
    t_rst = 1'b0;
    @(posedge clk); #1;
    t_v = 1'b1; acc = 0; seen = 1'b0; e1 = 1'b0; r1 = 8'hFF;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (t_psel && t_pen) acc++;
      if (t_ready) begin seen = 1'b1; e1 = t_err; r1 = t_rdata; t_v = 1'b0; end
    end
    chk("to_seen", seen, 1);
    chk("to_access_cycles", acc, 4);
    chk("to_err", e1, 1);
    chk("to_rdata", r1, 8'h00);
    @(posedge clk); #1;
    chk("to_back_idle", {t_busy, t_psel, t_pen, t_ready}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
